serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial WIDTH-bit adder/subtractor sequencer for the 4-bit ALU datapath.
- Sits directly upstream of a single `FA` full-adder cell and drives it.
- Presents one operand bit pair plus a registered carry per clock, LSB first.
- Collects each sum bit into a result shift register and reports carry-out and signed overflow.
- Provides the ALU's low-area add/sub path; the ALU control FSM drives the start/ready/done handshake.

## Interface
- WIDTH, 4, operand/result width in bits; legal range WIDTH ≥ 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only while ready=1.
- sub  in  1  0 = op_a+op_b, 1 = op_a−op_b; captured with the operands.
- op_a  in  WIDTH  first operand; captured on the accepting edge.
- op_b  in  WIDTH  second operand; captured on the accepting edge.
- ready  out  1  block idle and accepting start.
- busy  out  1  serial computation in progress.
- done  out  1  one-cycle pulse; result, cout and ovf are valid.
- result  out  WIDTH  sum/difference, registered.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow (op_a ≥ op_b unsigned).
- ovf  out  1  two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1, capture the operands and go to RUN:
  - sa ← op_a.
  - sb ← op_b XOR {WIDTH{sub}}.
  - carry ← sub.
  - bit counter ← 0.
- RUN: busy=1. FA inputs are a=sa[0], b=sb[0], cin=carry. Each edge:
  - shift sa and sb right.
  - shift FA sum into acc from the MSB side.
  - carry ← FA cout.
  - counter +1.
- RUN, last edge (counter = WIDTH−1), also:
  - result ← completed acc.
  - cout ← FA cout.
  - ovf ← FA cin XOR FA cout, i.e. carry into MSB XOR carry out of MSB.
  - go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- result, cout and ovf hold their values until the next DONE entry.
- start while in RUN or DONE is ignored; the operands in flight are unaffected.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- Bit counter width is $clog2(WIDTH).

## Timing
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, ovf=0. All internal registers clear.
- rst mid-operation aborts immediately. No done pulse is produced and the prior result is cleared.
- Accepting edge E0 → RUN. Bit k is processed at edge E(k+1). DONE is entered after edge E(WIDTH).
- done is high during the cycle after E(WIDTH), i.e. WIDTH+1 edges after acceptance.
- DONE → IDLE at E(WIDTH+1). The next accept is possible at E(WIDTH+2).
- Throughput: one operation per WIDTH+2 cycles; start held high gives back-to-back operations at that rate.
- ready and busy decode combinationally from state. done is high only in DONE.
- FA is purely combinational; the carry register is the only feedback path.

## Structure
- Shared package alu_pkg: state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10, and the ALU op codes ADD/SUB.
- One sub-module: the existing `FA` (ports a, b, cin, sum, cout), instantiated once as fa0.
- Everything else (FSM, shift registers, counter, output registers) lives in serial_addsub.

## Test plan
All cases at WIDTH=4.
- Reset:
  - Stimulus: assert rst two cycles into a RUN.
  - Response: ready=1, busy=0, done=0, result=0, cout=0, ovf=0 immediately; no done pulse afterwards.
- Add with overflow:
  - Stimulus: op_a=4'h5, op_b=4'h3, sub=0.
  - Response: done exactly 5 edges after accept; result=4'h8, cout=0, ovf=1.
- Add with wrap:
  - Stimulus: op_a=4'hF, op_b=4'h1, sub=0.
  - Response: result=4'h0, cout=1, ovf=0.
- Subtract:
  - Stimulus: op_a=4'h3, op_b=4'h5, sub=1 → result=4'hE, cout=0, ovf=0.
  - Stimulus: op_a=4'h8, op_b=4'h1, sub=1 → result=4'h7, cout=1, ovf=1.
- Start while busy:
  - Stimulus: start=1 with op_a=4'h9 during RUN of 4'h2+4'h2.
  - Response: result=4'h4; second request not accepted; ready stays 0 until after DONE.
- Back-to-back:
  - Stimulus: start held high with constant operands 4'h6+4'h7.
  - Response: done pulses every 6 cycles, each with result=4'hD, cout=0, ovf=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and add/sub op codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } alu_op_t;

endpackage

// File: rtl/serial_addsub_if.sv
// Start/ready/done handshake and operand/result bus of the bit-serial add/sub unit.
interface serial_addsub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, op_a, op_b,
    input  ready, busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output ready, busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_fa.sv
// Single-bit combinational full adder cell driven by the serial sequencer.
module FA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one FA evaluation per clock, LSB first,
// with a registered carry as the only feedback path.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  serial_addsub_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               fa_sum;
  logic               fa_cout;

  FA fa0 (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign acc_next = {fa_sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == IDLE);
    bus.busy  = (state == RUN);
    bus.done  = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            sa    <= bus.op_a;
            sb    <= bus.op_b ^ {WIDTH{bus.sub}};
            carry <= (bus.sub == SUB);
            cnt   <= '0;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          acc   <= acc_next;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            bus.result <= acc_next;
            bus.cout   <= fa_cout;
            bus.ovf    <= carry ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=4 against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ua, ub, sa, sb, r, sr;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    if (!s) begin
      r  = ua + ub;
      c  = (r >= 16);
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    v = (sr > 7) || (sr < -8);
    return {v, c, 4'(r & 15)};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
  endtask

  // Wait for done at negedges; returns number of posedges seen (bounded).
  task automatic wait_done(input string tag, output int edges);
    edges = 0;
    while (!bus.done && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!bus.done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic s);
    int edges;
    int waits;
    logic [5:0] exp;
    exp = model(a, b, s);
    waits = 0;
    while (!bus.ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(tag, edges);
    // Edges counted after the accepting edge; accept + 4 = 5 edges.
    check({tag, "_latency"}, 32'(edges + 1), 32'(W + 1));
    check({tag, "_result"},  32'(bus.result), 32'(exp[3:0]));
    check({tag, "_cout"},    32'(bus.cout),   32'(exp[4]));
    check({tag, "_ovf"},     32'(bus.ovf),    32'(exp[5]));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done),  32'd0);
    check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int edges;
    int cyc;
    int last_done;
    int pulses;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst");
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_cout",   32'(bus.cout),   32'd0);
    check("rst_ovf",    32'(bus.ovf),    32'd0);

    // Directed operations
    do_op("add_ovf",  4'h5, 4'h3, 1'b0);
    check("add_ovf_val", 32'(bus.result), 32'h8);
    do_op("add_wrap", 4'hF, 4'h1, 1'b0);
    check("add_wrap_val", 32'(bus.result), 32'h0);
    do_op("sub_neg",  4'h3, 4'h5, 1'b1);
    check("sub_neg_val", 32'(bus.result), 32'hE);
    do_op("sub_ovf",  4'h8, 4'h1, 1'b1);
    check("sub_ovf_val", 32'(bus.ovf), 32'd1);

    // Reset two cycles into a run: abort, clear prior result, no done afterwards
    bus.op_a = 4'h7; bus.op_b = 4'h6; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_cout",   32'(bus.cout),   32'd0);
    check("midrst_ovf",    32'(bus.ovf),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);

    // Start while busy is ignored
    bus.op_a = 4'h2; bus.op_b = 4'h2; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.op_a = 4'h9;
    check("busy_ready0", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("busy_ready1", 32'(bus.ready), 32'd0);
    bus.start = 1'b0;
    wait_done("busy", edges);
    check("busy_latency", 32'(edges + 2), 32'(W + 1));
    check("busy_result",  32'(bus.result), 32'h4);
    @(negedge clk);
    check("busy_idle_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check("busy_not_accepted", 32'(bus.busy), 32'd0);

    // Back-to-back with start held high
    bus.op_a = 4'h6; bus.op_b = 4'h7; bus.sub = 1'b0; bus.start = 1'b1;
    last_done = -1;
    pulses = 0;
    cyc = 0;
    while (pulses < 4 && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (last_done >= 0) check("b2b_interval", 32'(cyc - last_done), 32'(W + 2));
        check("b2b_result", 32'(bus.result), 32'hD);
        check("b2b_cout",   32'(bus.cout),   32'd0);
        check("b2b_ovf",    32'(bus.ovf),    32'd1);
        last_done = cyc;
        pulses++;
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd4);
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      do_op("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
